// File: rtl/load_unit_if.sv
// load_unit_if: request, data-memory and writeback signals of the load unit.
interface load_unit_if #(parameter int XLEN = 32);
  logic            ld_valid;
  logic            ld_ready;
  logic [2:0]      ld_funct3;
  logic [XLEN-1:0] ld_addr;
  logic [4:0]      ld_rd;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;
  modport master (
    output ld_valid, ld_funct3, ld_addr, ld_rd, mem_gnt, mem_rvalid, mem_rdata, wb_ready,
    input  ld_ready, mem_req, mem_addr, wb_valid, wb_rd, wb_data, wb_err
  );
  modport slave (
    input  ld_valid, ld_funct3, ld_addr, ld_rd, mem_gnt, mem_rvalid, mem_rdata, wb_ready,
    output ld_ready, mem_req, mem_addr, wb_valid, wb_rd, wb_data, wb_err
  );
endinterface

// File: rtl/load_unit.sv
// load_unit: RV32I load path issuing word-aligned reads and extending the addressed byte/half/word.
module load_unit #(
  parameter int XLEN    = 32,
  parameter int BIG_END = 1,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  load_unit_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t          state, state_n;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [CW-1:0]   cnt;
  logic            bad, timed_out;
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] r, input logic [2:0] f,
                                              input logic [1:0] off);
    logic [XLEN-1:0] sw;
    logic [7:0]      b;
    logic [15:0]     h;
    for (int i = 0; i < XLEN / 8; i++)
      sw[8*i +: 8] = (BIG_END != 0) ? r[XLEN-8-8*i +: 8] : r[8*i +: 8];
    b = sw[8*off +: 8];
    h = sw[16*off[1] +: 16];
    return f[1] ? sw :
           f[0] ? {{(XLEN-16){~f[2] & h[15]}}, h} :
                  {{(XLEN-8){~f[2] & b[7]}}, b};
  endfunction
  assign bad = (bus.ld_funct3 == 3'b011) || (bus.ld_funct3[2:1] == 2'b11) ||
               (bus.ld_funct3[1:0] == 2'b01 && bus.ld_addr[0]) ||
               (bus.ld_funct3 == 3'b010 && bus.ld_addr[1:0] != 2'b00);
  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign bus.ld_ready = (state == IDLE);
  assign bus.mem_req  = (state == REQ);
  assign bus.wb_valid = (state == RESP);
  assign bus.mem_addr = {addr[XLEN-1:2], 2'b00};
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.ld_valid ? (bad ? RESP : REQ) : IDLE;
      REQ:     state_n = bus.mem_gnt ? (bus.mem_rvalid ? RESP : WAIT) : REQ;
      WAIT:    state_n = (bus.mem_rvalid || timed_out) ? RESP : WAIT;
      default: state_n = bus.wb_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      funct3      <= '0;
      addr        <= '0;
      cnt         <= '0;
      bus.wb_rd   <= '0;
      bus.wb_data <= '0;
      bus.wb_err  <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (bus.ld_valid) begin
          funct3      <= bus.ld_funct3;
          addr        <= bus.ld_addr;
          bus.wb_rd   <= bus.ld_rd;
          bus.wb_err  <= bad;
          bus.wb_data <= '0;
          cnt         <= '0;
        end
        REQ: if (bus.mem_gnt && bus.mem_rvalid) bus.wb_data <= extract(bus.mem_rdata, funct3, addr[1:0]);
        WAIT: begin
          cnt <= (bus.mem_rvalid || timed_out) ? '0 : cnt + CW'(1);
          if (bus.mem_rvalid) bus.wb_data <= extract(bus.mem_rdata, funct3, addr[1:0]);
          else if (timed_out) begin
            bus.wb_err  <= 1'b1;
            bus.wb_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: drives little- and big-endian load units in lockstep against a behavioural load model.
module tb_load_unit;
  logic        clk = 1'b0;
  logic        rst, ld_valid, gnt, rvalid, wb_ready;
  logic [2:0]  f3;
  logic [31:0] addr, rdata;
  logic [4:0]  rd;
  int n_chk = 0, n_err = 0;
  load_unit_if #(.XLEN(32)) le ();
  load_unit_if #(.XLEN(32)) be ();
  assign le.ld_valid = ld_valid;   assign be.ld_valid = ld_valid;
  assign le.ld_funct3 = f3;        assign be.ld_funct3 = f3;
  assign le.ld_addr = addr;        assign be.ld_addr = addr;
  assign le.ld_rd = rd;            assign be.ld_rd = rd;
  assign le.mem_gnt = gnt;         assign be.mem_gnt = gnt;
  assign le.mem_rvalid = rvalid;   assign be.mem_rvalid = rvalid;
  assign le.mem_rdata = rdata;     assign be.mem_rdata = rdata;
  assign le.wb_ready = wb_ready;   assign be.wb_ready = wb_ready;
  load_unit #(.XLEN(32), .BIG_END(0), .TIMEOUT(4)) dut_le (.clk(clk), .rst(rst), .bus(le));
  load_unit #(.XLEN(32), .BIG_END(1), .TIMEOUT(4)) dut_be (.clk(clk), .rst(rst), .bus(be));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic bit model_err(input logic [2:0] f, input logic [31:0] a);
    int size;
    if (f == 3'b011 || f >= 3'b110) return 1'b1;
    size = 1 << f[1:0];
    return (int'(a[1:0]) % size) != 0;
  endfunction
  function automatic logic [31:0] model_data(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] r, input bit big);
    logic [31:0] w, v;
    int off;
    w = big ? {<<8{r}} : r;
    off = int'(a[1:0]);
    v = 32'h0;
    case (f)
      3'b000: begin v = (w >> (8 * off)) & 32'hFF; if (v >= 128) v = v - 256; end
      3'b001: begin v = (w >> (16 * (off / 2))) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'b010: v = w;
      3'b100: v = (w >> (8 * off)) & 32'hFF;
      3'b101: v = (w >> (16 * (off / 2))) & 32'hFFFF;
      default: v = 32'h0;
    endcase
    return v;
  endfunction
  task automatic check_idle(input string tag);
    check({tag, ":ld_ready"}, le.ld_ready, 1);
    check({tag, ":be_ld_ready"}, be.ld_ready, 1);
    check({tag, ":mem_req"}, le.mem_req, 0);
    check({tag, ":wb_valid"}, le.wb_valid, 0);
    check({tag, ":be_wb_valid"}, be.wb_valid, 0);
  endtask
  // rvd < 0 means rvalid never comes and the load must time out
  task automatic do_load(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [4:0] r, input logic [31:0] data,
                         input int gd, input int rvd, input int hold);
    bit bad, err;
    int lat, c;
    logic [31:0] exp_le, exp_be;
    bad = model_err(f, a);
    err = bad || rvd < 0;
    lat = bad ? 1 : 2 + gd + (rvd < 0 ? 4 : rvd);
    exp_le = err ? 32'h0 : model_data(f, a, data, 1'b0);
    exp_be = err ? 32'h0 : model_data(f, a, data, 1'b1);
    check({tag, ":ld_ready"}, le.ld_ready, 1);
    ld_valid = 1'b1; f3 = f; addr = a; rd = r;
    tick;
    ld_valid = 1'b0; f3 = 3'($urandom); addr = $urandom; rd = 5'($urandom);
    for (c = 1; c < 20 && !le.wb_valid; c++) begin
      check({tag, ":mem_req"}, le.mem_req, (!bad && c <= 1 + gd) ? 1 : 0);
      check({tag, ":be_mem_req"}, be.mem_req, (!bad && c <= 1 + gd) ? 1 : 0);
      if (!bad && c <= 1 + gd) check({tag, ":mem_addr"}, le.mem_addr, {a[31:2], 2'b00});
      gnt = !bad && c == 1 + gd;
      rvalid = !bad && rvd >= 0 && c == 1 + gd + rvd;
      rdata = rvalid ? data : $urandom;
      tick;
    end
    gnt = 1'b0; rvalid = 1'b0;
    check({tag, ":latency"}, c, lat);
    for (int h = 0; h <= hold; h++) begin
      check({tag, ":wb_valid"}, le.wb_valid, 1);
      check({tag, ":wb_data"}, le.wb_data, exp_le);
      check({tag, ":be_wb_data"}, be.wb_data, exp_be);
      check({tag, ":wb_err"}, le.wb_err, err);
      check({tag, ":be_wb_err"}, be.wb_err, err);
      check({tag, ":wb_rd"}, le.wb_rd, r);
      check({tag, ":ld_ready_resp"}, le.ld_ready, 0);
      wb_ready = (h == hold);
      tick;
    end
    wb_ready = 1'b0;
    check_idle({tag, ":after"});
  endtask
  initial begin
    logic [2:0] rf;
    int rv;
    rst = 1'b1; ld_valid = 1'b0; gnt = 1'b0; rvalid = 1'b0; wb_ready = 1'b0;
    f3 = '0; addr = '0; rd = '0; rdata = '0;
    tick; tick;
    check_idle("reset");
    check("reset:wb_err", le.wb_err, 0);
    check("reset:wb_data", le.wb_data, 0);
    check("reset:wb_rd", le.wb_rd, 0);
    check("reset:mem_addr", le.mem_addr, 0);
    rst = 1'b0;
    tick;
    do_load("lw", 3'b010, 32'h100, 5'd3, 32'h8844_2211, 0, 1, 0);
    do_load("lb", 3'b000, 32'h103, 5'd4, 32'h80FF_0000, 0, 1, 0);
    do_load("lbu", 3'b100, 32'h103, 5'd5, 32'h80FF_0000, 0, 1, 0);
    do_load("lh", 3'b001, 32'h202, 5'd6, 32'h1122_F344, 1, 2, 0);
    do_load("lw_mis", 3'b010, 32'h101, 5'd7, 32'h1234_5678, 0, 1, 0);
    do_load("illegal", 3'b011, 32'h100, 5'd8, 32'h1234_5678, 0, 1, 0);
    do_load("rd0", 3'b101, 32'h0FE, 5'd0, 32'hABCD_9876, 0, 0, 0);
    do_load("timeout", 3'b000, 32'h040, 5'd9, 32'hDEAD_BEEF, 0, -1, 0);
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    tick;
    rvalid = 1'b0;
    check_idle("late_rvalid");
    do_load("hold", 3'b101, 32'h302, 5'd10, 32'h9ABC_DEF0, 2, 3, 5);
    ld_valid = 1'b1; f3 = 3'b010; addr = 32'h400; rd = 5'd11;
    tick;
    ld_valid = 1'b0; gnt = 1'b1;
    tick;
    gnt = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_idle("mid_rst");
    check("mid_rst:wb_err", le.wb_err, 0);
    check("mid_rst:mem_addr", le.mem_addr, 0);
    rvalid = 1'b1; rdata = 32'h1111_2222;
    tick;
    rvalid = 1'b0;
    check_idle("mid_rst_rvalid");
    for (int i = 0; i < 60; i++) begin
      rf = 3'($urandom_range(0, 7));
      rv = $urandom_range(0, 5);
      do_load("rand", rf, $urandom, 5'($urandom), $urandom, $urandom_range(0, 3),
              rv == 5 ? -1 : rv, $urandom_range(0, 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Read-side data-memory port of the RV32I core.
- Accepts a LOAD micro-op from the MEM stage (funct3 plus byte address) and issues a word-aligned read on the data-memory bus.
- Waits for the response, then extracts the addressed byte, halfword or word, sign- or zero-extends it, and hands it to writeback.
- Counterpart of the store path's byte-enable/mask generation; the two share the same endianness convention.

Parameters:
- XLEN, 32, datapath and address width.
- BIG_END, 1, lane order: 1 = big-endian (byte offset 0 at rdata[31:24]); 0 = little-endian (byte offset 0 at rdata[7:0]).
- TIMEOUT, 255, maximum cycles spent in WAIT before an error response. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  load request valid.
- ld_ready  out  1  unit can accept a request.
- ld_funct3  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101.
- ld_addr  in  XLEN  byte address.
- ld_rd  in  5  destination register.
- mem_req  out  1  bus read request.
- mem_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}.
- mem_gnt  in  1  request accepted by memory.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- wb_valid  out  1  result valid.
- wb_ready  in  1  writeback accepts result.
- wb_rd  out  5  destination register of the result.
- wb_data  out  XLEN  extended load data.
- wb_err  out  1  misaligned, illegal funct3, or timeout.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- On reset:
  - Unit enters IDLE.
  - ld_ready=1; mem_req=0, wb_valid=0, wb_err=0.
  - wb_data=0, wb_rd=0, mem_addr=0; timeout counter=0.
  - Reset mid-operation abandons the transaction; any later mem_rvalid is ignored while in IDLE.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - ld_ready=1.
  - On ld_valid, register funct3, addr and rd, and drop ld_ready.
  - If the request is an error (misaligned or illegal funct3, defined below), go to RESP with wb_err=1 and wb_data=0; no bus request is made.
  - Otherwise go to REQ.
- Error checks:
  - Misaligned: LH/LHU with addr[0]=1; LW with addr[1:0]!=0.
  - Illegal funct3: 011, 110, 111.
- REQ:
  - mem_req=1 and mem_addr held stable until mem_gnt.
  - On mem_gnt, drop mem_req next cycle and go to WAIT.
  - If mem_gnt and mem_rvalid occur in the same cycle, capture rdata and go directly to RESP.
- WAIT:
  - Counter increments each cycle.
  - On mem_rvalid, capture mem_rdata, go to RESP, clear counter.
  - If the counter reaches TIMEOUT without mem_rvalid, go to RESP with wb_err=1 and wb_data=0.
- RESP:
  - wb_valid=1 with wb_data, wb_rd and wb_err held stable until wb_ready.
  - On wb_valid && wb_ready, return to IDLE; ld_ready rises the following cycle. No back-to-back acceptance in the handshake cycle.
- Extraction, with off = addr[1:0]:
  - Little-endian (BIG_END=0): byte = rdata[8*off+7 : 8*off]; half = rdata[16*off[1]+15 : 16*off[1]].
  - Big-endian (BIG_END=1): rdata is byte-swapped (rdata[7:0]↔rdata[31:24], rdata[15:8]↔rdata[23:16]) before the little-endian rule is applied.
  - Word loads are returned swapped or unswapped per BIG_END.
- Extension:
  - LB/LH replicate bit 7 or bit 15 into the upper bits.
  - LBU/LHU zero-fill the upper bits.
  - Extraction is registered into wb_data on entry to RESP.
- Latency, best case (gnt on the first REQ cycle, rvalid one cycle later):
  - Accept at T0, mem_req at T1, rvalid at T2, wb_valid at T3.
- ld_rd=0 is passed through unchanged; suppressing the x0 write is the register file's job.

Test Plan:
- LW, addr 0x100, BIG_END=0, rdata 0x8844_2211, gnt at T1, rvalid at T2 -> mem_addr=0x100; wb_valid at T3 with wb_data=0x8844_2211, wb_err=0.
- LB and LBU, addr 0x103, BIG_END=0, rdata 0x80FF_0000 -> LB gives wb_data=0xFFFF_FF80; LBU gives 0x0000_0080; mem_addr=0x100.
- LH, addr 0x202, BIG_END=1, rdata 0x1122_F344 -> swapped 0x44F3_2211, upper half 0x44F3; wb_data=0x0000_44F3.
- LW at 0x101, and funct3=011 at 0x100 -> no mem_req; wb_valid the cycle after accept with wb_err=1, wb_data=0.
- TIMEOUT=4, mem_gnt given, mem_rvalid never asserted -> wb_err=1 after 4 WAIT cycles; a late rvalid in IDLE is ignored and ld_ready=1.
- wb_ready held low for 5 cycles in RESP, then rst pulsed mid-WAIT on a second load -> outputs stable until wb_ready; after rst, mem_req=0, wb_valid=0, ld_ready=1.
